// File: rtl/transfer_host_arbiter.sv
// Round-robin arbiter that shares the 30-bit uc_out transfer-command bus between N_CH requesters.
// Define TRANSFER_ARB_TIMEOUT_EN to bound the host-busy wait by TIMEOUT_CYCLES and raise a sticky timeout_err.
module transfer_host_arbiter #(
  parameter int N_CH           = 4,
  parameter int BASE_ADDR      = 0,
  parameter int HOLD_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                uc_clk,
  input  logic                uc_reset,
  input  logic [31:0]         uc_in,
  output logic [29:0]         uc_out,
  input  logic [N_CH-1:0]     req,
  input  logic [8*N_CH-1:0]   req_byte,
  output logic [N_CH-1:0]     ack,
  output logic [N_CH-1:0]     done,
  output logic                arb_busy,
  output logic                timeout_err
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    GRANT     = 5'b00010,
    DRIVE     = 5'b00100,
    WAIT_HOST = 5'b01000,
    DONE      = 5'b10000
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] sel_reg;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic [7:0]       byte_reg;
  logic [3:0]       hold_cnt_reg;
  logic [2:0]       ch_addr;
  logic [29:0]      frame;
  logic             host_busy;
  logic [30:0]      unused_uc_in;

  logic [IDX_W:0]   rot_sum [N_CH];
  logic [IDX_W-1:0] rot_idx [N_CH];

  assign host_busy    = uc_in[31];
  assign unused_uc_in = uc_in[30:0];

  // rot_idx[gi] is the channel examined gi places after the pointer, wrapping at N_CH
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
      assign rot_sum[gi] = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
      assign rot_idx[gi] = (rot_sum[gi] >= (IDX_W+1)'(N_CH))
                         ? IDX_W'(rot_sum[gi] - (IDX_W+1)'(N_CH))
                         : rot_sum[gi][IDX_W-1:0];
    end
  endgenerate

  // Walk from the farthest candidate back so the one nearest the pointer wins
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (req[rot_idx[j]]) begin
        pick_valid = 1'b1;
        pick_idx   = rot_idx[j];
      end
    end
  end

  assign ptr_next = (sel_reg == IDX_W'(N_CH - 1)) ? '0 : sel_reg + 1'b1;
  assign ch_addr  = 3'(BASE_ADDR) + 3'(sel_reg);
  assign frame    = {ch_addr, 9'b0, 1'b1, byte_reg, 9'b0};
  assign arb_busy = (state_reg != IDLE);

`ifdef TRANSFER_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;
  logic        timeout_err_reg;
  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      sel_reg      <= '0;
      byte_reg     <= '0;
      hold_cnt_reg <= '0;
      uc_out       <= '0;
      ack          <= '0;
      done         <= '0;
`ifdef TRANSFER_ARB_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
      timeout_err_reg <= 1'b0;
`endif
    end else begin
      ack    <= '0;
      done   <= '0;
      uc_out <= '0;
      unique case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            sel_reg   <= pick_idx;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          byte_reg      <= req_byte[{sel_reg, 3'b000} +: 8];
          ack[sel_reg]  <= 1'b1;
          ptr_reg       <= ptr_next;
          hold_cnt_reg  <= '0;
          state_reg     <= DRIVE;
        end
        DRIVE: begin
          uc_out <= frame;
          if (hold_cnt_reg == 4'(HOLD_CYCLES - 1)) begin
            hold_cnt_reg <= '0;
            state_reg    <= WAIT_HOST;
`ifdef TRANSFER_ARB_TIMEOUT_EN
            tmo_cnt_reg  <= '0;
`endif
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 4'd1;
          end
        end
        WAIT_HOST: begin
          if (!host_busy) begin
            done[sel_reg] <= 1'b1;
            state_reg     <= DONE;
          end
`ifdef TRANSFER_ARB_TIMEOUT_EN
          else if (tmo_cnt_reg == 16'(TIMEOUT_CYCLES - 1)) begin
            done[sel_reg]   <= 1'b1;
            timeout_err_reg <= 1'b1;
            state_reg       <= DONE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
          end
`endif
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
